// File: rtl/cache_sa_if.sv
// CPU-side and memory-side bus bundle for the 2-way set-associative cache.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface cache_sa_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              cpu_req;
   logic              w_en;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_flush;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              hit;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  cpu_req, w_en, address, cpu_wdata, cpu_flush, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, hit, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, w_en, address, cpu_wdata, cpu_flush, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, hit, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_sa.sv
// 2-way set-associative, write-through, no-write-allocate cache with LRU
// replacement, memory req/ack miss handling and a whole-cache flush.
module cache_sa #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int SET_BITS = 4
) (
   input logic      clk_1,
   input logic      rst,
   cache_sa_if.slave bus
);
   localparam int SETS  = 1 << SET_BITS;
   localparam int TAG_W = ADDR_W - SET_BITS;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOOKUP = 2'd1;
   localparam logic [1:0] MEM_RD = 2'd2;
   localparam logic [1:0] MEM_WR = 2'd3;

   logic [1:0]        state_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              we_r;
   logic              wr_hit_r;
   logic              hit_way_r;

   logic [DATA_W-1:0] cpu_rdata_r;
   logic              cpu_ready_r;
   logic              hit_r;
   logic              mem_req_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;

   logic [TAG_W-1:0]  tag_r  [2][SETS];
   logic [DATA_W-1:0] data_r [2][SETS];
   logic [SETS-1:0]   valid_r [2];
   logic [SETS-1:0]   lru_r;

   logic [SET_BITS-1:0] idx_s;
   logic [TAG_W-1:0]    tag_s;
   logic                match0_s;
   logic                match1_s;
   logic                hit_s;
   logic [DATA_W-1:0]   hit_data_s;
   logic                victim_s;

   assign bus.cpu_rdata = cpu_rdata_r;
   assign bus.cpu_ready = cpu_ready_r;
   assign bus.hit       = hit_r;
   assign bus.mem_req   = mem_req_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;

   // Tag compare of the latched address and victim choice (invalid way first, else LRU).
   always_comb begin
      idx_s      = addr_r[SET_BITS-1:0];
      tag_s      = addr_r[ADDR_W-1:SET_BITS];
      match0_s   = valid_r[0][idx_s] && (tag_r[0][idx_s] == tag_s);
      match1_s   = valid_r[1][idx_s] && (tag_r[1][idx_s] == tag_s);
      hit_s      = match0_s || match1_s;
      hit_data_s = data_r[0][idx_s];
      victim_s   = lru_r[idx_s];
      if (match1_s) begin
         hit_data_s = data_r[1][idx_s];
      end else begin
         hit_data_s = data_r[0][idx_s];
      end
      if (!valid_r[0][idx_s]) begin
         victim_s = 1'b0;
      end else if (!valid_r[1][idx_s]) begin
         victim_s = 1'b1;
      end else begin
         victim_s = lru_r[idx_s];
      end
   end

   // Control FSM and all registered bus outputs; cpu_ready defaults low so it only pulses.
   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         wdata_r     <= {DATA_W{1'b0}};
         we_r        <= 1'b0;
         wr_hit_r    <= 1'b0;
         hit_way_r   <= 1'b0;
         cpu_rdata_r <= {DATA_W{1'b0}};
         cpu_ready_r <= 1'b0;
         hit_r       <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
      end else begin
         cpu_ready_r <= 1'b0;
         hit_r       <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!bus.cpu_flush && bus.cpu_req) begin
                  addr_r  <= bus.address;
                  wdata_r <= bus.cpu_wdata;
                  we_r    <= bus.w_en;
                  state_r <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (we_r) begin
                  wr_hit_r    <= hit_s;
                  hit_way_r   <= match1_s;
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= 1'b1;
                  mem_addr_r  <= addr_r;
                  mem_wdata_r <= wdata_r;
                  state_r     <= MEM_WR;
               end else if (hit_s) begin
                  cpu_ready_r <= 1'b1;
                  hit_r       <= 1'b1;
                  cpu_rdata_r <= hit_data_s;
                  state_r     <= IDLE;
               end else begin
                  mem_req_r  <= 1'b1;
                  mem_we_r   <= 1'b0;
                  mem_addr_r <= addr_r;
                  state_r    <= MEM_RD;
               end
            end
            MEM_RD: begin
               if (bus.mem_ack) begin
                  cpu_rdata_r <= bus.mem_rdata;
                  cpu_ready_r <= 1'b1;
                  mem_req_r   <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            MEM_WR: begin
               if (bus.mem_ack) begin
                  cpu_ready_r <= 1'b1;
                  hit_r       <= wr_hit_r;
                  mem_req_r   <= 1'b0;
                  mem_we_r    <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Valid and LRU bookkeeping; lru_r[set] names the way to evict next.
   always_ff @(posedge clk_1 or posedge rst) begin
      if (rst) begin
         valid_r[0] <= {SETS{1'b0}};
         valid_r[1] <= {SETS{1'b0}};
         lru_r      <= {SETS{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.cpu_flush) begin
                  valid_r[0] <= {SETS{1'b0}};
                  valid_r[1] <= {SETS{1'b0}};
               end
            end
            LOOKUP: begin
               if (!we_r && hit_s) begin
                  lru_r[idx_s] <= ~match1_s;
               end
            end
            MEM_RD: begin
               if (bus.mem_ack) begin
                  valid_r[victim_s][idx_s] <= 1'b1;
                  lru_r[idx_s]             <= ~victim_s;
               end
            end
            MEM_WR: begin
               if (bus.mem_ack && wr_hit_r) begin
                  lru_r[idx_s] <= ~hit_way_r;
               end
            end
            default: lru_r <= lru_r;
         endcase
      end
   end

   // Tag/data storage is deliberately not reset; only valid bits make lines live.
   always_ff @(posedge clk_1) begin
      if (state_r == MEM_RD && bus.mem_ack) begin
         tag_r[victim_s][idx_s]  <= tag_s;
         data_r[victim_s][idx_s] <= bus.mem_rdata;
      end else if (state_r == MEM_WR && bus.mem_ack && wr_hit_r) begin
         data_r[hit_way_r][idx_s] <= wdata_r;
      end
   end
endmodule

// File: tb/tb_cache_sa.sv
// Randomised scoreboard bench for cache_sa: a recency-list cache model plus a
// flat memory model predict every completion; a monitor pops and compares.
module tb_cache_sa;
   localparam int AW = 16;
   localparam int DW = 8;

   logic clk_1 = 1'b0;
   logic rst;
   always #5 clk_1 = ~clk_1;

   cache_sa_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   cache_sa #(.ADDR_W(AW), .DATA_W(DW), .SET_BITS(4)) dut (
      .clk_1(clk_1),
      .rst  (rst),
      .bus  (bus)
   );

   typedef struct {
      logic       exp_hit;
      logic [7:0] exp_rdata;
      logic       is_read;
      logic       exp_mem;
      int         issue;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] resident[$];          // resident addresses, oldest use first
   logic [7:0]  env_mem [logic [15:0]];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          ack_delay = 0;
   logic        mem_seen = 1'b0;
   logic [15:0] cur_addr = 16'h0000;
   logic        cur_we = 1'b0;
   logic [7:0]  cur_wdata = 8'h00;

   always @(posedge clk_1) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      if (env_mem.exists(a)) return env_mem[a];
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic model_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                               output logic h);
      int pos = -1;
      int same = 0;
      int first = -1;
      foreach (resident[i]) if (resident[i] == a) pos = i;
      h = (pos >= 0);
      if (we) env_mem[a] = wd;
      if (h) begin
         resident.delete(pos);
         resident.push_back(a);
      end else if (!we) begin
         foreach (resident[i]) begin
            if (resident[i][3:0] == a[3:0]) begin
               same++;
               if (first < 0) first = i;
            end
         end
         if (same >= 2) resident.delete(first);
         resident.push_back(a);
      end
   endtask

   task automatic access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                         input logic with_flush);
      exp_t e;
      logic h;
      int   target;
      if (with_flush) resident.delete();
      model_access(we, a, wd, h);
      e.exp_hit   = h;
      e.exp_rdata = we ? 8'h00 : mem_rd(a);
      e.is_read   = !we;
      e.exp_mem   = we || !h;
      e.issue     = cyc;
      sb.push_back(e);
      cur_addr  = a;
      cur_we    = we;
      cur_wdata = wd;
      mem_seen  = 1'b0;
      target    = done_cnt + 1;
      bus.address   = a;
      bus.w_en      = we;
      bus.cpu_wdata = wd;
      bus.cpu_req   = 1'b1;
      bus.cpu_flush = with_flush;
      if (with_flush) begin
         @(negedge clk_1); #1;
         bus.cpu_flush = 1'b0;
      end
      for (int k = 0; k < 60 && done_cnt < target; k++) begin
         @(negedge clk_1); #1;
      end
      chk("access_completed", 32'(done_cnt >= target), 32'd1);
      bus.cpu_req = 1'b0;
   endtask

   // monitor: pops the scoreboard whenever the cache completes an access
   initial begin
      exp_t e;
      logic prev_ready = 1'b0;
      forever begin
         @(negedge clk_1);
         if (bus.cpu_ready === 1'b1) begin
            chk("ready_single_cycle", 32'(prev_ready), 32'd0);
            chk("scoreboard_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("hit", 32'(bus.hit), 32'(e.exp_hit));
               if (e.is_read) chk("rdata", 32'(bus.cpu_rdata), 32'(e.exp_rdata));
               chk("mem_access", 32'(mem_seen), 32'(e.exp_mem));
               if (e.is_read && e.exp_hit) chk("hit_latency", 32'(cyc - e.issue), 32'd2);
            end
            done_cnt++;
         end
         prev_ready = bus.cpu_ready;
      end
   end

   // memory responder: checks request fields and acks after ack_delay cycles
   initial begin
      logic        busy = 1'b0;
      int          wc = 0;
      logic [15:0] held = 16'h0000;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(negedge clk_1);
         bus.mem_ack = 1'b0;
         if (bus.mem_req === 1'b1) begin
            chk("ready_low_during_mem", 32'(bus.cpu_ready), 32'd0);
            if (!busy) begin
               busy     = 1'b1;
               wc       = 0;
               mem_seen = 1'b1;
               held     = bus.mem_addr;
               chk("mem_addr", 32'(bus.mem_addr), 32'(cur_addr));
               chk("mem_we", 32'(bus.mem_we), 32'(cur_we));
               if (cur_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cur_wdata));
            end else begin
               chk("mem_addr_stable", 32'(bus.mem_addr), 32'(held));
            end
            if (wc >= ack_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = cur_we ? 8'h00 : mem_rd(cur_addr);
               busy          = 1'b0;
            end else begin
               wc++;
            end
         end else begin
            busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      rst           = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.w_en      = 1'b0;
      bus.address   = 16'h0000;
      bus.cpu_wdata = 8'h00;
      bus.cpu_flush = 1'b0;
      #1;
      chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
      chk("rst_hit", 32'(bus.hit), 32'd0);
      chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      repeat (3) @(negedge clk_1);
      rst = 1'b0;
      @(negedge clk_1); #1;

      env_mem[16'h1234] = 8'h5A;
      access(1'b0, 16'h1234, 8'h00, 1'b0);
      access(1'b0, 16'h1234, 8'h00, 1'b0);

      ack_delay = 2;
      access(1'b0, 16'h0010, 8'h00, 1'b0);
      access(1'b0, 16'h0020, 8'h00, 1'b0);
      access(1'b0, 16'h0010, 8'h00, 1'b0);
      access(1'b0, 16'h0030, 8'h00, 1'b0);
      access(1'b0, 16'h0010, 8'h00, 1'b0);
      access(1'b0, 16'h0020, 8'h00, 1'b0);

      ack_delay = 1;
      access(1'b1, 16'h1234, 8'hC3, 1'b0);
      access(1'b0, 16'h1234, 8'h00, 1'b0);
      access(1'b1, 16'h4444, 8'h77, 1'b0);
      access(1'b0, 16'h4444, 8'h00, 1'b0);

      ack_delay = 5;
      access(1'b0, 16'h0040, 8'h00, 1'b0);

      // reset while a read miss is outstanding
      ack_delay     = 1000;
      cur_addr      = 16'h0100;
      cur_we        = 1'b0;
      bus.address   = 16'h0100;
      bus.w_en      = 1'b0;
      bus.cpu_req   = 1'b1;
      for (int k = 0; k < 10 && bus.mem_req !== 1'b1; k++) begin
         @(negedge clk_1); #1;
      end
      @(negedge clk_1); #1;
      chk("pre_reset_mem_req", 32'(bus.mem_req), 32'd1);
      bus.cpu_req = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_drop_mem_req", 32'(bus.mem_req), 32'd0);
      chk("async_ready_low", 32'(bus.cpu_ready), 32'd0);
      resident.delete();
      repeat (2) @(negedge clk_1);
      rst = 1'b0;
      ack_delay = 0;
      @(negedge clk_1); #1;
      access(1'b0, 16'h1234, 8'h00, 1'b0);

      access(1'b0, 16'h1234, 8'h00, 1'b0);
      access(1'b0, 16'h1234, 8'h00, 1'b1);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 99) < 4) begin
            bus.cpu_flush = 1'b1;
            resident.delete();
            @(negedge clk_1); #1;
            bus.cpu_flush = 1'b0;
         end else begin
            a[15:4]   = 12'h100 + 12'($urandom_range(0, 3));
            a[3:0]    = 4'($urandom_range(0, 2));
            ack_delay = $urandom_range(0, 3);
            access($urandom_range(0, 99) < 30, a, 8'($urandom), 1'b0);
         end
      end

      repeat (5) @(negedge clk_1);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end
endmodule
